// File: rtl/ladybird_mmio_stream_bridge.sv
// Memory-mapped bridge from the core data bus to N_CH push/pop stream channels.
// Each channel exposes a DATA and a STATUS word; stalled data accesses can time out.
module ladybird_mmio_stream_bridge #(
  parameter int          N_CH      = 2,
  parameter int          DATA_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int          TIMEOUT   = 0,
  parameter logic [31:0] ERR_VALUE = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     anrst,
  input  logic                     bus_req,
  input  logic [31:0]              bus_addr,
  input  logic [3:0]               bus_wstrb,
  input  logic [31:0]              bus_wdata,
  output logic                     bus_gnt,
  output logic [31:0]              bus_rdata,
  output logic                     bus_rvalid,
  output logic [N_CH*DATA_W-1:0]   tx_data,
  output logic [N_CH-1:0]          tx_valid,
  input  logic [N_CH-1:0]          tx_ready,
  input  logic [N_CH*DATA_W-1:0]   rx_data,
  input  logic [N_CH-1:0]          rx_valid,
  output logic [N_CH-1:0]          rx_ready
);

  // state   | meaning
  // IDLE    | ready for a request, bus_gnt high
  // RD_DATA | popping the selected channel, waiting for rx_valid or timeout
  // WR_DATA | pushing the selected channel, waiting for tx_ready or timeout
  // RESP    | single-cycle STATUS / unmapped completion

  localparam int                CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int                TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0]       WIN_SIZE = 32'(8 * N_CH);
  localparam logic [TMR_W-1:0]  T_LAST   = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, RD_DATA, WR_DATA, RESP} state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                w1c_q;
  logic [TMR_W-1:0]    timer_q;
  logic [N_CH-1:0]     flag_q;
  logic [N_CH-1:0]     set_flag, clr_flag;

  logic [31:0]         off_in, off_q;
  logic                mapped_in, mapped_q;
  logic [CH_W-1:0]     ch_q;
  logic                accept, expire;
  logic                tx_ready_c, rx_valid_c;
  logic [DATA_W-1:0]   rx_data_c;
  logic [31:0]         status_c;
  logic                unused_wdata;

  assign off_in    = bus_addr - BASE_ADDR;
  assign mapped_in = off_in < WIN_SIZE;
  assign off_q     = addr_q - BASE_ADDR;
  assign mapped_q  = off_q < WIN_SIZE;
  assign ch_q      = off_q[3 +: CH_W];

  assign accept = bus_req && (state_q == IDLE);
  assign expire = (TIMEOUT > 0) && (timer_q == T_LAST);

  assign tx_ready_c   = tx_ready[ch_q];
  assign rx_valid_c   = rx_valid[ch_q];
  assign rx_data_c    = rx_data[ch_q*DATA_W +: DATA_W];
  assign status_c     = {29'd0, flag_q[ch_q], rx_valid_c, tx_ready_c};
  assign unused_wdata = ^bus_wdata;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      w1c_q   <= 1'b0;
      timer_q <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      // a timeout set in the same cycle as a W1C clear must survive
      flag_q  <= (flag_q & ~clr_flag) | set_flag;
      if (accept) begin
        addr_q  <= bus_addr;
        write_q <= |bus_wstrb;
        wdata_q <= bus_wdata[DATA_W-1:0];
        w1c_q   <= bus_wdata[2];
        timer_q <= '0;
      end else if (state_q == RD_DATA || state_q == WR_DATA) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    tx_valid   = '0;
    tx_data    = '0;
    rx_ready   = '0;
    set_flag   = '0;
    clr_flag   = '0;
    case (state_q)
      IDLE: begin
        bus_gnt = 1'b1;
        if (bus_req) begin
          if (!mapped_in || off_in[2]) state_d = RESP;
          else if (|bus_wstrb)         state_d = WR_DATA;
          else                         state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        rx_ready[ch_q] = 1'b1;
        if (rx_valid_c) begin
          bus_rvalid = 1'b1;
          bus_rdata  = 32'(rx_data_c);
          state_d    = IDLE;
        end else if (expire) begin
          bus_rvalid     = 1'b1;
          bus_rdata      = ERR_VALUE;
          set_flag[ch_q] = 1'b1;
          state_d        = IDLE;
        end
      end
      WR_DATA: begin
        tx_valid[ch_q]                 = 1'b1;
        tx_data[ch_q*DATA_W +: DATA_W] = wdata_q;
        if (tx_ready_c) begin
          state_d = IDLE;
        end else if (expire) begin
          set_flag[ch_q] = 1'b1;
          state_d        = IDLE;
        end
      end
      RESP: begin
        if (!write_q) begin
          bus_rvalid = 1'b1;
          bus_rdata  = mapped_q ? status_c : 32'd0;
        end else if (mapped_q && w1c_q) begin
          clr_flag[ch_q] = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ladybird_mmio_stream_bridge.sv
// Bench for ladybird_mmio_stream_bridge: scripted cycle-level stimulus, with read data
// and channel pushes checked against expectation queues as the DUT produces them.
module tb_ladybird_mmio_stream_bridge;
  localparam int          N_CH   = 2;
  localparam int          DATA_W = 8;
  localparam logic [31:0] BASE   = 32'hFFFF_FF00;

  logic                   clk = 1'b0;
  logic                   anrst;
  logic                   bus_req;
  logic [31:0]            bus_addr;
  logic [3:0]             bus_wstrb;
  logic [31:0]            bus_wdata;
  logic                   bus_gnt;
  logic [31:0]            bus_rdata;
  logic                   bus_rvalid;
  logic [N_CH*DATA_W-1:0] tx_data;
  logic [N_CH-1:0]        tx_valid;
  logic [N_CH-1:0]        tx_ready;
  logic [N_CH*DATA_W-1:0] rx_data;
  logic [N_CH-1:0]        rx_valid;
  logic [N_CH-1:0]        rx_ready;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd_q[$];
  logic [31:0] tx_q[$];

  ladybird_mmio_stream_bridge #(
    .N_CH(N_CH), .DATA_W(DATA_W), .BASE_ADDR(BASE), .TIMEOUT(8), .ERR_VALUE(32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .anrst(anrst),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // enters at cycle t (just after the edge), returns just after the edge of t+1
  task automatic drive_req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus_req   = 1'b1;
    bus_addr  = a;
    bus_wstrb = s;
    bus_wdata = d;
    smp();
    check("gnt_at_accept", 32'(bus_gnt), 32'd1);
    step();
    bus_req   = 1'b0;
    bus_wstrb = 4'h0;
    bus_wdata = 32'h0;
  endtask

  // scoreboard: read data and channel pushes
  always @(negedge clk) begin
    if (anrst) begin
      if (bus_rvalid) begin
        if (rd_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
        else                  check("rdata", bus_rdata, rd_q.pop_front());
      end
      for (int c = 0; c < N_CH; c++) begin
        if (tx_valid[c] && tx_ready[c]) begin
          if (tx_q.size() == 0) check("tx_push_unexpected", 32'd1, 32'd0);
          else                  check("tx_data", 32'(tx_data[c*DATA_W +: DATA_W]), tx_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    anrst = 1'b0; bus_req = 1'b0; bus_addr = '0; bus_wstrb = '0; bus_wdata = '0;
    tx_ready = '0; rx_data = '0; rx_valid = '0;
    smp();
    check("rst_gnt", 32'(bus_gnt), 32'd1);
    check("rst_rvalid", 32'(bus_rvalid), 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    step();
    anrst = 1'b1;
    step();

    // status read of channel 1
    tx_ready = 2'b10;
    rd_q.push_back(32'h1);
    drive_req(BASE + 32'hC, 4'h0, 32'h0);
    smp();
    check("st_rvalid_t1", 32'(bus_rvalid), 32'd1);
    check("st_gnt_t1", 32'(bus_gnt), 32'd0);
    step(); smp();
    check("st_gnt_t2", 32'(bus_gnt), 32'd1);
    check("st_rvalid_t2", 32'(bus_rvalid), 32'd0);
    check("rdata_idle", bus_rdata, 32'd0);

    // data write channel 0 with back-pressure
    step();
    tx_ready = 2'b00;
    tx_q.push_back(32'hA5);
    drive_req(BASE, 4'hF, 32'h1234_56A5);
    for (int i = 1; i <= 3; i++) begin
      smp();
      check("wr_tx_valid_wait", 32'(tx_valid), 32'h1);
      check("wr_tx_data0", 32'(tx_data[7:0]), 32'hA5);
      check("wr_gnt_wait", 32'(bus_gnt), 32'd0);
      step();
    end
    tx_ready = 2'b01;
    smp();
    check("wr_tx_valid_hs", 32'(tx_valid), 32'h1);
    check("wr_no_rvalid", 32'(bus_rvalid), 32'd0);
    step();
    tx_ready = 2'b00;
    smp();
    check("wr_tx_valid_done", 32'(tx_valid), 32'h0);
    check("wr_gnt_done", 32'(bus_gnt), 32'd1);

    // data read channel 1, rx_valid at t+4
    step();
    rx_data = 16'h3C00;
    rd_q.push_back(32'h3C);
    drive_req(BASE + 32'h8, 4'h0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      smp();
      check("rd_rx_ready_wait", 32'(rx_ready), 32'h2);
      check("rd_rvalid_wait", 32'(bus_rvalid), 32'd0);
      step();
    end
    rx_valid = 2'b10;
    smp();
    check("rd_rvalid_t4", 32'(bus_rvalid), 32'd1);
    check("rd_rx_ready_t4", 32'(rx_ready), 32'h2);
    step();
    rx_valid = 2'b00;
    smp();
    check("rd_rx_ready_t5", 32'(rx_ready), 32'h0);
    check("rd_gnt_t5", 32'(bus_gnt), 32'd1);

    // read timeout on channel 0
    step();
    rd_q.push_back(32'hFFFF_FFFF);
    drive_req(BASE, 4'h0, 32'h0);
    for (int i = 1; i <= 7; i++) begin
      smp();
      check("to_rvalid_wait", 32'(bus_rvalid), 32'd0);
      check("to_rx_ready_wait", 32'(rx_ready), 32'h1);
      step();
    end
    smp();
    check("to_rvalid_t8", 32'(bus_rvalid), 32'd1);
    step(); smp();
    check("to_rx_ready_t9", 32'(rx_ready), 32'h0);
    check("to_gnt_t9", 32'(bus_gnt), 32'd1);
    step();
    rd_q.push_back(32'h4);
    drive_req(BASE + 32'h4, 4'h0, 32'h0);
    smp(); step();
    drive_req(BASE + 32'h4, 4'hF, 32'h4);
    smp(); step();
    rd_q.push_back(32'h0);
    drive_req(BASE + 32'h4, 4'h0, 32'h0);
    smp(); step();

    // write timeout on channel 1
    drive_req(BASE + 32'h8, 4'hF, 32'h77);
    for (int i = 1; i <= 8; i++) begin
      smp();
      check("wto_tx_valid_wait", 32'(tx_valid), 32'h2);
      step();
    end
    smp();
    check("wto_tx_valid_t9", 32'(tx_valid), 32'h0);
    check("wto_gnt_t9", 32'(bus_gnt), 32'd1);
    step();
    rd_q.push_back(32'h4);
    drive_req(BASE + 32'hC, 4'h0, 32'h0);
    smp(); step();
    rd_q.push_back(32'h0);
    drive_req(BASE + 32'h4, 4'h0, 32'h0);
    smp(); step();

    // unmapped accesses
    rd_q.push_back(32'h0);
    drive_req(BASE + 32'h40, 4'h0, 32'h0);
    smp();
    check("um_rvalid_t1", 32'(bus_rvalid), 32'd1);
    step();
    rd_q.push_back(32'h0);
    drive_req(BASE + 32'h10, 4'h0, 32'h0);
    smp(); step();
    drive_req(BASE + 32'h40, 4'hF, 32'hAA);
    smp();
    check("umw_tx_valid", 32'(tx_valid), 32'h0);
    check("umw_rvalid", 32'(bus_rvalid), 32'd0);
    check("umw_gnt_t1", 32'(bus_gnt), 32'd0);
    step(); smp();
    check("umw_gnt_t2", 32'(bus_gnt), 32'd1);
    step();

    // reset in the middle of a data read
    drive_req(BASE, 4'h0, 32'h0);
    smp();
    check("mid_rx_ready", 32'(rx_ready), 32'h1);
    step();
    anrst = 1'b0;
    #1;
    check("arst_gnt", 32'(bus_gnt), 32'd1);
    check("arst_rvalid", 32'(bus_rvalid), 32'd0);
    check("arst_rdata", bus_rdata, 32'd0);
    check("arst_tx_valid", 32'(tx_valid), 32'h0);
    check("arst_rx_ready", 32'(rx_ready), 32'h0);
    step(); step();
    anrst = 1'b1;
    tx_ready = 2'b10;
    rd_q.push_back(32'h1);
    drive_req(BASE + 32'hC, 4'h0, 32'h0);
    smp(); step();
    rx_valid = 2'b01;
    rx_data  = 16'h005A;
    rd_q.push_back(32'h5A);
    drive_req(BASE, 4'h0, 32'h0);
    smp();
    check("post_rst_rvalid_t1", 32'(bus_rvalid), 32'd1);
    step();
    rx_valid = 2'b00;
    step(); step();

    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ladybird_mmio_stream_bridge.md
Name: ladybird_mmio_stream_bridge

Overview:
- Memory-mapped bridge between the core data bus and N_CH byte/word stream channels (UART-class peripherals).
- Successor to the single-channel, fixed-address (all-ones) UART hookup. Adds:
  - parametrised channel count, data width and base address;
  - a per-channel status register;
  - an optional request timeout with a sticky error flag.
- Sits between ladybird_core's data bus and the serial interfaces in the top level.

Parameters:
- N_CH, 2, number of stream channels (1..16).
- DATA_W, 8, channel payload width (1..32).
- BASE_ADDR, 32'hFFFF_FF00, base of the window. Aligned to 8*2^ceil(log2(N_CH)).
- TIMEOUT, 0, cycles a data access may wait before aborting. 0 = wait forever.
- ERR_VALUE, 32'hFFFF_FFFF, read data returned on a timed-out data read.

Ports:
- clk  in  1  clock
- anrst  in  1  asynchronous active-low reset
- bus_req  in  1  request valid
- bus_addr  in  32  byte address
- bus_wstrb  in  4  write strobes. Nonzero = write, zero = read.
- bus_wdata  in  32  write data
- bus_gnt  out  1  bridge can accept a request this cycle
- bus_rdata  out  32  read data
- bus_rvalid  out  1  one-cycle read-data pulse
- tx_data  out  N_CH*DATA_W  per-channel push data
- tx_valid  out  N_CH  push valid
- tx_ready  in  N_CH  push ready
- rx_data  in  N_CH*DATA_W  per-channel pop data
- rx_valid  in  N_CH  pop valid
- rx_ready  out  N_CH  pop ready

Behaviour:
- Address map, channel c:
  - DATA register at BASE_ADDR+8c.
  - STATUS register at BASE_ADDR+8c+4.
  - addr[1:0] ignored.
- Any address outside BASE_ADDR..BASE_ADDR+8*N_CH-1 is "unmapped".
- STATUS layout:
  - bit0 = tx_ready[c], live.
  - bit1 = rx_valid[c], live.
  - bit2 = timeout sticky flag.
  - bits 31:3 = 0.
- Reset (anrst low, asynchronous): state IDLE, bus_gnt=1, bus_rvalid=0, bus_rdata=0, tx_valid=0, rx_ready=0, sticky flags=0, latches=0, timer=0.
- Handshake: a request is accepted in cycle t when bus_req & bus_gnt. At acceptance the bridge latches addr, wstrb!=0, and wdata[DATA_W-1:0]. bus_gnt = (state==IDLE), so at most one request is outstanding.
- FSM states: IDLE, RD_DATA, WR_DATA, RESP.
  - IDLE, accepted DATA read → RD_DATA.
  - IDLE, accepted DATA write → WR_DATA.
  - IDLE, accepted STATUS or unmapped access → RESP.
  - RD_DATA:
    - rx_ready[c]=1 (only the selected channel).
    - When rx_valid[c], in that same cycle: bus_rvalid=1, bus_rdata = zero-extended rx_data[c], then → IDLE.
    - Minimum latency: rvalid at t+1.
  - WR_DATA:
    - tx_valid[c]=1, tx_data[c] = latched data.
    - On tx_ready[c] → IDLE.
    - Write completion is signalled only by bus_gnt returning at t+2 or later. No rvalid for writes.
  - RESP, cycle t+1:
    - Reads: bus_rvalid=1. bus_rdata = STATUS value sampled in that cycle, or 0 if unmapped.
    - STATUS write: wdata bit2=1 clears channel c's sticky flag (W1C). Other bits ignored.
    - Unmapped write: dropped silently.
    - → IDLE.
- Timeout (TIMEOUT>0):
  - Timer clears on entering RD_DATA/WR_DATA and increments each cycle there.
  - If the timer reaches TIMEOUT-1 with no handshake:
    - read: bus_rvalid=1, bus_rdata=ERR_VALUE, rx_ready drops;
    - write: tx_valid drops, data discarded;
    - channel sticky flag set; → IDLE.
  - A handshake in the same cycle as expiry wins: normal completion, no flag.
- Sticky flag set and W1C clear in the same cycle: the set wins.
- bus_rdata holds 0 whenever bus_rvalid=0.
- tx_valid/rx_ready are 0 on all non-selected channels at all times.
- Partial wstrb is treated as a full write of the low DATA_W bits.
- DATA_W<32: upper write bits ignored, read zero-extended.

Test Plan:
- Reset, then N_CH=2, status read of channel 1 at BASE+0xC with tx_ready=2'b10, rx_valid=0 → rvalid at t+1, rdata=32'h1. bus_gnt back at t+2.
- Data write 32'h1234_56A5 to BASE+0 with tx_ready[0] low 3 cycles, then high → tx_valid[0] high from t+1 to the tx_ready cycle, tx_data[0]=8'hA5, tx_valid[1]=0 throughout, bus_gnt low meanwhile.
- Data read BASE+8 with rx_valid[1] rising at t+4, rx_data[1]=8'h3C → rvalid at t+4, rdata=32'h3C, rx_ready[1] high t+1..t+4 only.
- TIMEOUT=8, data read channel 0 with rx_valid never asserted → rvalid at t+8, rdata=32'hFFFF_FFFF. Status read then returns bit2=1. Write 32'h4 to BASE+4, re-read → bit2=0.
- Unmapped read BASE+0x40 → rvalid at t+1, rdata=0. Unmapped write → no tx_valid, gnt at t+2.
- anrst asserted mid-RD_DATA → outputs immediately at reset values. Next request after release is handled normally.
